// File: rtl/dot_reduce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dot_reduce : sums LEN dot results, optional ReLU, saturates to int8 | rev 1.0
// ---------------------------------------------------------------------------
module dot_reduce #(
  parameter int LEN   = 4,
  parameter int ACC_W = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       relu_en,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data
);

  localparam int                      CNT_W = (LEN > 2) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0]        LAST  = CNT_W'(LEN - 1);
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(-128);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]              state;
  logic [0:0]              state_nxt;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] sum_relu;
  logic [7:0]              result;
  logic                    accept;
  logic                    final_acc;

  // Only a final beat can stall, and only against an unacknowledged result.
  assign in_ready  = !(out_valid && !out_ready && (cnt == LAST));
  assign accept    = in_valid && in_ready;
  assign final_acc = accept && (cnt == LAST);

  assign sum      = acc + {{(ACC_W-8){in_data[7]}}, in_data};
  assign sum_relu = (relu_en && sum < 0) ? '0 : sum;

  always_comb begin
    result = sum_relu[7:0];
    if (sum_relu > MAX_V) begin
      result = 8'h7F;
    end else if (sum_relu < MIN_V) begin
      result = 8'h80;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (final_acc) state_nxt = FULL;
      FULL:    if (out_ready && !final_acc) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state == FULL);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc      <= '0;
      cnt      <= '0;
      out_data <= '0;
    end else if (final_acc) begin
      acc      <= '0;
      cnt      <= '0;
      out_data <= result;
    end else if (accept) begin
      acc <= sum;
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dot_reduce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dot_reduce : directed bench for dot_reduce | rev 1.0
// ---------------------------------------------------------------------------
module tb_dot_reduce;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       relu_en;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  int n_cmp = 0;
  int n_err = 0;

  dot_reduce #(.LEN(4), .ACC_W(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .relu_en   (relu_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Present one beat at a negedge and hold it until accepted (bounded).
  task automatic send(input logic [7:0] d, input logic r);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    relu_en  = r;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check("accept_timeout", 16'd0, 16'd1);
    tick();
    in_valid = 1'b0;
    relu_en  = 1'b0;
  endtask

  task automatic group4(input logic [7:0] a, b, c, d, input logic r_last);
    send(a, 1'b0);
    send(b, 1'b0);
    send(c, 1'b0);
    send(d, r_last);
  endtask

  initial begin
    int gaps [4] = '{1, 3, 0, 2};
    logic [7:0] gdat [4] = '{8'd2, 8'd3, 8'd4, 8'd5};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    relu_en   = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_out_data", {8'd0, out_data}, 16'd0);
    check("rst_in_ready", {15'd0, in_ready}, 16'd1);

    // Plain sum, single-cycle output with out_ready high
    group4(8'd10, 8'd20, 8'd30, 8'd40, 1'b0);
    check("sum_valid", {15'd0, out_valid}, 16'd1);
    check("sum_data", {8'd0, out_data}, 16'd100);
    tick();
    check("sum_one_cycle", {15'd0, out_valid}, 16'd0);

    group4(8'd100, 8'd100, 8'd100, 8'd100, 1'b0);
    check("sat_pos", {8'd0, out_data}, 16'h007F);
    group4(8'h9C, 8'h9C, 8'h9C, 8'h9C, 1'b0);
    check("sat_neg", {8'd0, out_data}, 16'h0080);
    group4(8'hFB, 8'd1, 8'd1, 8'd1, 1'b0);
    check("neg_sum", {8'd0, out_data}, 16'h00FE);
    group4(8'hFB, 8'd1, 8'd1, 8'd1, 1'b1);
    check("relu_zero", {8'd0, out_data}, 16'h0000);
    send(8'd0, 1'b1);
    send(8'd0, 1'b0);
    send(8'd0, 1'b0);
    send(8'hFD, 1'b0);
    check("relu_first_only", {8'd0, out_data}, 16'h00FD);
    tick();

    // Backpressure: 8 beats of 1 with out_ready low
    out_ready = 1'b0;
    group4(8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
    check("bp_valid1", {15'd0, out_valid}, 16'd1);
    check("bp_data1", {8'd0, out_data}, 16'd4);
    send(8'd1, 1'b0);
    send(8'd1, 1'b0);
    send(8'd1, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'd1;
    check("bp_stall", {15'd0, in_ready}, 16'd0);
    tick();
    check("bp_stall_hold", {15'd0, in_ready}, 16'd0);
    check("bp_data_stable", {8'd0, out_data}, 16'd4);
    out_ready = 1'b1;
    #1;
    check("bp_release", {15'd0, in_ready}, 16'd1);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("bp_valid2", {15'd0, out_valid}, 16'd1);
    check("bp_data2", {8'd0, out_data}, 16'd4);
    out_ready = 1'b1;
    tick();
    check("bp_drained", {15'd0, out_valid}, 16'd0);

    // Reset mid-group discards the partial sum
    send(8'd7, 1'b0);
    send(8'd7, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_valid", {15'd0, out_valid}, 16'd0);
    send(8'd1, 1'b0);
    send(8'd1, 1'b0);
    check("midrst_no_partial", {15'd0, out_valid}, 16'd0);
    send(8'd1, 1'b0);
    send(8'd1, 1'b0);
    check("midrst_valid2", {15'd0, out_valid}, 16'd1);
    check("midrst_data", {8'd0, out_data}, 16'd4);
    tick();

    // Gapped input with out_ready toggling
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        out_ready = ~out_ready;
        tick();
        check("gap_no_output", {15'd0, out_valid}, 16'd0);
      end
      out_ready = ~out_ready;
      send(gdat[i], 1'b0);
    end
    out_ready = 1'b0;
    check("gap_valid", {15'd0, out_valid}, 16'd1);
    check("gap_data", {8'd0, out_data}, 16'd14);
    tick();
    check("gap_hold_valid", {15'd0, out_valid}, 16'd1);
    check("gap_hold_data", {8'd0, out_data}, 16'd14);
    out_ready = 1'b1;
    tick();
    check("gap_drained", {15'd0, out_valid}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dot_reduce.md
Name: dot_reduce

Overview:
- Downstream stage of the dot unit; consumes its 8-bit signed result stream `y`.
- Sums LEN consecutive accepted results into a wide accumulator, applies optional ReLU, and saturates the sum to 8-bit signed.
- Presents each group result on a one-entry valid/ready output register feeding the next layer.
- Exerts backpressure only when the output register is still occupied at the moment a new group completes.

Parameters:
- LEN, 4, number of input beats per output group (LEN >= 2).
- ACC_W, 16, accumulator width in bits (ACC_W >= 8 + clog2(LEN)).

Ports:
- clock  input  1  single clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data carries a dot result.
- in_ready  output  1  stage can accept in_data this cycle.
- in_data  input  8  signed dot result (`y` of the dot unit).
- relu_en  input  1  clamp negative group sums to 0; sampled on the final beat of a group.
- out_valid  output  1  out_data holds a finished group result.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  8  signed saturated (optionally ReLU'd) group sum.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are named `clock` and `reset`.
- Reset values: acc=0, cnt=0, out_valid=0, out_data=0. in_ready reads 1 in the cycle after reset.
- Reset mid-group discards the partial sum and any pending output. No output is ever produced for a discarded group.
- Accept condition: accept = in_valid && in_ready.
- Sign extension: in_data is sign-extended to ACC_W before addition.
- cnt counts accepted beats 0..LEN-1 and wraps to 0 on the final beat.
- Non-final accept (cnt != LEN-1): acc <= acc + sext(in_data); cnt <= cnt+1.
- Final accept (cnt == LEN-1):
  - sum = acc + sext(in_data).
  - If relu_en and sum < 0, sum = 0.
  - Saturate: sum > 127 gives 127; sum < -128 gives -128.
  - out_data <= result; out_valid <= 1; acc <= 0; cnt <= 0.
- Latency: out_valid rises on the clock edge that accepts the final beat, so it is visible the cycle after that beat is presented.
- Output FSM states: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY -> FULL on a final accept.
  - FULL -> EMPTY on out_ready with no simultaneous final accept.
  - FULL -> FULL when out_ready and a final accept occur together; out_data is replaced with the new result with no bubble.
- out_data and out_valid are stable while out_valid=1 and out_ready=0.
- in_ready = !(out_valid && !out_ready && cnt == LEN-1).
  - Non-final beats are always accepted; accumulation continues while output is pending.
  - Only a final beat stalls against a full, unacknowledged output register.
  - in_ready is combinational from out_ready. The consumer must not make out_ready depend on in_ready.
- Gaps: in_valid=0 cycles leave acc and cnt unchanged. Gaps of any length are allowed between beats.
- out_valid is independent of in_valid except through a final accept.
- No overflow can occur inside acc within the ACC_W constraint. Saturation happens only at the output.
- relu_en is ignored on non-final beats.

Test Plan:
- Plain sum (relu_en=0, out_ready=1): beats 10,20,30,40 back-to-back -> out_valid=1 with out_data=100 the cycle after the 4th beat, for exactly one cycle.
- Saturation: beats 100,100,100,100 -> 127. Then beats -100,-100,-100,-100 -> -128 (8'h80).
- Sign handling and ReLU: beats -5,1,1,1 with relu_en=0 -> -2 (8'hFE). Same beats with relu_en=1 on the final beat -> 0. relu_en=1 only on the first beat of 0,0,0,-3 -> -3.
- Backpressure (out_ready=0): feed 8 beats of 1 continuously.
  - After beat 4: out_valid=1, out_data=4.
  - Beats 5-7 are accepted; beat 8 sees in_ready=0 and is held.
  - Pulse out_ready for one cycle: first group (4) drains, beat 8 is accepted in that same cycle, and next cycle out_data=4 (second group) with out_valid=1.
- Reset mid-operation: accept beats 7,7, assert reset for 1 cycle, then accept 1,1,1,1 -> single output of 4. No output of the partial group ever appears.
- Gapped input: beats 2,3,4,5 separated by 0-3 idle cycles, with out_ready toggling every cycle -> out_data=14 held stable until handshake. cnt and acc are unchanged across idle cycles.
